// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation select codes, RV32I opcode and funct7
// constants, the decoded-issue record and the immediate sign-extension helper.
package alu_pkg;

  // ALU operation select as seen by the execute stage
  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SLL  = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SRA  = 4'd5,
    ALU_SUB  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SLLI = 4'd10,
    ALU_SRLI = 4'd11,
    ALU_NOR  = 4'd12,
    ALU_SRAI = 4'd13
  } alu_op_e;

  // RV32I major opcodes handled by the issue stage
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct7 values: base encoding and the SUB/SRA alternate
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // One decoded operation as held in the issue slot or skid entry
  typedef struct packed {
    alu_op_e     alu_sel;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;
  } issue_t;

  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I decode into ALU select, operands, destination and
// write-back enable. Undecodable words produce an all-zero operation with
// illegal set; rd always reflects instr[11:7].
module alu_issue_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output issue_t      dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_f;
  logic       legal;
  logic       wb_class;
  issue_t     raw;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd_f   = instr[11:7];

  // Per-opcode decode; legality and write-back class resolved alongside
  always_comb begin
    raw      = '0;
    raw.rd   = rd_f;
    legal    = 1'b1;
    wb_class = 1'b0;
    case (opcode)
      OPC_OP: begin
        raw.op_a = rs1_data;
        raw.op_b = rs2_data;
        wb_class = 1'b1;
        case (funct3)
          3'b000:  raw.alu_sel = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          3'b001:  raw.alu_sel = ALU_SLL;
          3'b010:  raw.alu_sel = ALU_SLT;
          3'b011:  raw.alu_sel = ALU_SLTU;
          3'b100:  raw.alu_sel = ALU_XOR;
          3'b101:  raw.alu_sel = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          3'b110:  raw.alu_sel = ALU_OR;
          default: raw.alu_sel = ALU_AND;
        endcase
        // Only SUB and SRA may use the alternate funct7
        if (!((funct7 == F7_BASE) ||
              ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))))
          legal = 1'b0;
      end
      OPC_OP_IMM: begin
        raw.op_a = rs1_data;
        raw.op_b = sext12(instr[31:20]);
        wb_class = 1'b1;
        case (funct3)
          3'b000: raw.alu_sel = ALU_ADD;
          3'b010: raw.alu_sel = ALU_SLT;
          3'b011: raw.alu_sel = ALU_SLTU;
          3'b100: raw.alu_sel = ALU_XOR;
          3'b110: raw.alu_sel = ALU_OR;
          3'b111: raw.alu_sel = ALU_AND;
          3'b001: begin
            raw.alu_sel = ALU_SLLI;
            raw.op_b    = {27'b0, instr[24:20]};
            if (funct7 != F7_BASE) legal = 1'b0;
          end
          default: begin
            raw.alu_sel = (funct7 == F7_ALT) ? ALU_SRAI : ALU_SRLI;
            raw.op_b    = {27'b0, instr[24:20]};
            if ((funct7 != F7_BASE) && (funct7 != F7_ALT)) legal = 1'b0;
          end
        endcase
      end
      OPC_LUI: begin
        raw.alu_sel = ALU_ADD;
        raw.op_a    = 32'd0;
        raw.op_b    = {instr[31:12], 12'b0};
        wb_class    = 1'b1;
      end
      OPC_AUIPC: begin
        raw.alu_sel = ALU_ADD;
        raw.op_a    = pc;
        raw.op_b    = {instr[31:12], 12'b0};
        wb_class    = 1'b1;
      end
      OPC_LOAD: begin
        raw.alu_sel = ALU_ADD;
        raw.op_a    = rs1_data;
        raw.op_b    = sext12(instr[31:20]);
        wb_class    = 1'b1;
      end
      OPC_STORE: begin
        raw.alu_sel = ALU_ADD;
        raw.op_a    = rs1_data;
        raw.op_b    = sext12({instr[31:25], instr[11:7]});
      end
      OPC_BRANCH: begin
        raw.op_a = rs1_data;
        raw.op_b = rs2_data;
        case (funct3)
          3'b000, 3'b001: raw.alu_sel = ALU_SUB;
          3'b100, 3'b101: raw.alu_sel = ALU_SLT;
          3'b110, 3'b111: raw.alu_sel = ALU_SLTU;
          default:        legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal words still issue, but as a harmless zero operation
  always_comb begin
    dec = raw;
    if (!legal) begin
      dec         = '0;
      dec.rd      = rd_f;
      dec.illegal = 1'b1;
    end else begin
      dec.wb_en = wb_class && (rd_f != 5'd0);
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: one registered issue slot in front of the execute stage,
// fed by alu_issue_decode. Define ALU_ISSUE_SKID_EN to add a second (skid)
// entry so that in_ready becomes a registered "skid empty" flag.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never waits on ready, and while out_valid && !out_ready every
// output holds. flush wins over any same-cycle transfer on either side.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_sel,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [4:0]  rd,
  output logic        wb_en,
  output logic        illegal
);

  issue_t dec;
  issue_t out_q;
  logic   out_valid_q;
  logic   accept;

  alu_issue_decode u_decode (
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dec      (dec)
  );

  assign accept = in_valid && in_ready;

`ifdef ALU_ISSUE_SKID_EN
  issue_t skid_q;
  logic   skid_valid_q;
  logic   in_ready_q;

  // Issue slot plus skid entry; the skid catches an accept made while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (out_valid_q && !out_ready) begin
      if (accept) begin
        skid_q       <= dec;
        skid_valid_q <= 1'b1;
        in_ready_q   <= 1'b0;
      end
    end else if (skid_valid_q) begin
      out_q        <= skid_q;
      out_valid_q  <= 1'b1;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (accept) begin
      out_q       <= dec;
      out_valid_q <= 1'b1;
      in_ready_q  <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end
  end

  assign in_ready = in_ready_q;
`else
  // Single issue slot: load on accept, empty on consume, cleared by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_q       <= dec;
      out_valid_q <= 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Ready whenever the slot is free or draining; forced low during reset
  assign in_ready = rst_n && (!out_valid_q || out_ready);
`endif

  assign out_valid = out_valid_q;
  assign alu_sel   = out_q.alu_sel;
  assign op_a      = out_q.op_a;
  assign op_b      = out_q.op_b;
  assign rd        = out_q.rd;
  assign wb_en     = out_q.wb_en;
  assign illegal   = out_q.illegal;

endmodule
